// File: rtl/kbd_event_ctrl_pkg.sv
// Shared constants for the PS/2 set-2 event sequencer: prefix bytes, modifier
// scancodes, parser state encoding and the event word layout.
package kbd_event_ctrl_pkg;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_FA = 8'hFA;
    localparam logic [7:0] B_EE = 8'hEE;
    localparam logic [7:0] B_00 = 8'h00;
    localparam logic [7:0] B_FF = 8'hFF;

    localparam logic [7:0] MOD_LSHIFT = 8'h12;
    localparam logic [7:0] MOD_RSHIFT = 8'h59;
    localparam logic [7:0] MOD_CTRL   = 8'h14;
    localparam logic [7:0] MOD_ALT    = 8'h11;

    // Pause sends E1 followed by seven more bytes that carry no key event.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam int EV_W       = 10;
    localparam int EV_EXT_BIT = 9;
    localparam int EV_BRK_BIT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    function automatic logic [EV_W-1:0] pack_ev(input logic ext, input logic brk,
                                                input logic [7:0] code);
        return {ext, brk, code};
    endfunction

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// Byte input from the PS/2 receiver and the valid/ready event output toward
// the consumer. The event sequencer uses the slave view.
interface kbd_event_ctrl_if;
    logic [7:0] byte_in;
    logic       byte_stb;
    logic       parity_err;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (
        output byte_in, byte_stb, parity_err, ev_ready,
        input  ev_valid, ev_code, ev_ext, ev_break
    );

    modport slave (
        input  byte_in, byte_stb, parity_err, ev_ready,
        output ev_valid, ev_code, ev_ext, ev_break
    );
endinterface

// File: rtl/kbd_event_fifo.sv
// Small synchronous FIFO with occupancy count. The head word is read
// combinationally from register storage and reads as zero while empty.
module kbd_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // When full, a simultaneous pop frees the slot the push writes into.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Turns the PS/2 set-2 byte stream into {ext, brk, code} key events, tracks
// modifier keys and queues events toward the consumer.
module kbd_event_ctrl
    import kbd_event_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                        clk,
    input  logic                        rst,
    kbd_event_ctrl_if.slave             bus,
    output logic [3:0]                  mods,
    output logic [$clog2(FIFO_DEPTH):0] ev_count,
    output logic                        overflow,
    input  logic                        clr_ovf,
    output logic                        seq_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t          r_state, w_state_next;
    logic [2:0]      r_skip, w_skip_next;
    logic [TW-1:0]   r_to_cnt;
    logic [3:0]      r_mods, w_mods_next;
    logic            r_seq_err, w_seq_err_next;
    logic            r_overflow;
    logic            w_emit, w_ext, w_brk;
    logic            w_full, w_empty, w_pop;
    logic [EV_W-1:0] w_head;

    assign w_pop = !w_empty && bus.ev_ready;

    always_comb begin
        w_state_next   = r_state;
        w_skip_next    = r_skip;
        w_seq_err_next = 1'b0;
        w_emit         = 1'b0;
        w_ext          = 1'b0;
        w_brk          = 1'b0;
        if (bus.byte_stb) begin
            if (bus.parity_err) begin
                w_state_next   = ST_IDLE;
                w_skip_next    = '0;
                w_seq_err_next = 1'b1;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.byte_in == B_E0) w_state_next = ST_EXT;
                        else if (bus.byte_in == B_F0) w_state_next = ST_BRK;
                        else if (bus.byte_in == B_E1) begin
                            w_state_next = ST_SKIP;
                            w_skip_next  = PAUSE_TAIL;
                        end else if (bus.byte_in == B_AA || bus.byte_in == B_FA ||
                                     bus.byte_in == B_EE) begin
                            w_state_next = ST_IDLE;
                        end else if (bus.byte_in == B_00 || bus.byte_in == B_FF) begin
                            w_seq_err_next = 1'b1;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (bus.byte_in == B_F0) begin
                            w_state_next = ST_EXT_BRK;
                        end else begin
                            w_emit       = 1'b1;
                            w_ext        = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        w_emit       = 1'b1;
                        w_brk        = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        w_emit       = 1'b1;
                        w_ext        = 1'b1;
                        w_brk        = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                    ST_SKIP: begin
                        w_skip_next = r_skip - 1'b1;
                        if (r_skip <= 3'd1) begin
                            w_skip_next  = '0;
                            w_state_next = ST_IDLE;
                        end
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end
        end else if (r_state != ST_IDLE && r_to_cnt == TW'(TIMEOUT_CYC)) begin
            w_state_next   = ST_IDLE;
            w_skip_next    = '0;
            w_seq_err_next = 1'b1;
        end
    end

    // Modifiers follow every emitted event, even one the FIFO has to drop.
    always_comb begin
        w_mods_next = r_mods;
        if (w_emit) begin
            if (!w_ext && bus.byte_in == MOD_LSHIFT) w_mods_next[0] = !w_brk;
            if (!w_ext && bus.byte_in == MOD_RSHIFT) w_mods_next[1] = !w_brk;
            if (bus.byte_in == MOD_CTRL)             w_mods_next[2] = !w_brk;
            if (bus.byte_in == MOD_ALT)              w_mods_next[3] = !w_brk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_skip     <= '0;
            r_to_cnt   <= '0;
            r_mods     <= '0;
            r_seq_err  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_skip    <= w_skip_next;
            r_mods    <= w_mods_next;
            r_seq_err <= w_seq_err_next;
            if (bus.byte_stb || r_state == ST_IDLE) r_to_cnt <= '0;
            else if (r_to_cnt != TW'(TIMEOUT_CYC))  r_to_cnt <= r_to_cnt + 1'b1;
            if (w_emit && w_full && !w_pop) r_overflow <= 1'b1;
            else if (clr_ovf)               r_overflow <= 1'b0;
        end
    end

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_emit),
        .i_wdata (pack_ev(w_ext, w_brk, bus.byte_in)),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (ev_count)
    );

    assign bus.ev_valid = !w_empty;
    assign bus.ev_code  = w_head[7:0];
    assign bus.ev_ext   = w_head[EV_EXT_BIT];
    assign bus.ev_break = w_head[EV_BRK_BIT];
    assign mods         = r_mods;
    assign overflow     = r_overflow;
    assign seq_err      = r_seq_err;

endmodule
